bridge_sequencer: RTL and testbench

Parametrised command sequencer between the frame parser, the AXI4-Lite master and the frame builder of the UART-AXI4 bridge. It replaces the fixed four-state main controller with:
- a latched command context;
- bounded retry with backoff on retryable AXI status;
- a response-completion watchdog;
- saturating, clearable statistics counters of configurable width.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/bridge_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bridge_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// ----------------------------------------------------------------------------
// bridge_pkg
// Shared types and constants for the UART-AXI4 bridge command sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   STATUS_*       : status codes seen on the AXI and response paths
//   is_retryable() : true for AXI statuses that justify a re-issue
// ----------------------------------------------------------------------------
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AXI_REQ   = 3'd1,
    BACKOFF   = 3'd2,
    BUILD     = 3'd3,
    WAIT_RESP = 3'd4
  } seq_state_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h04;
  localparam logic [7:0] STATUS_BUSY    = 8'h06;

  // Only transient slave conditions are worth another attempt.
  function automatic logic is_retryable(input logic [7:0] status);
    return (status == STATUS_BUSY) || (status == STATUS_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Registered up-counter that sticks at all-ones and has a synchronous clear.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   inc_i     : add one this cycle (ignored once saturated)
//   clr_i     : synchronous clear, wins over inc_i
//   value_o   : current count
// ----------------------------------------------------------------------------
module sat_counter
  import bridge_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && (value_q != '1)) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/bridge_sequencer.sv
// ----------------------------------------------------------------------------
// bridge_sequencer
// Command sequencer between the frame parser, the AXI4-Lite master and the
// frame builder. Latches the command context, re-issues AXI transactions on
// transient status with a fixed backoff, guards the builder handshake with a
// watchdog and keeps saturating statistics.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   frame_valid_i/frame_error_i : parser holds a good / errored frame
//   parser_error_status_i       : status code for an errored frame
//   parser_cmd_i/parser_addr_i  : CMD byte (bit 7 = read) and address
//   frame_consumed_o            : one-cycle release pulse to the parser
//   axi_start_o                 : AXI transaction request (level)
//   axi_done_i/axi_status_i     : AXI completion strobe and result code
//   axi_rd_count_i              : read bytes returned, valid with axi_done_i
//   build_response_o            : one-cycle builder trigger
//   status_code_o, cmd_echo_o,
//   addr_echo_o,
//   is_read_response_o,
//   resp_data_count_o           : response fields, zero outside BUILD/WAIT_RESP
//   response_complete_i         : builder finished
//   stats_clear_i               : clears counters and the timeout flag
//   wr/rd/err/retry_count_o     : saturating statistics
//   resp_timeout_flag_o         : sticky builder-watchdog flag
//   seq_busy_o                  : sequencer not idle
// ----------------------------------------------------------------------------
module bridge_sequencer
  import bridge_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int BACKOFF_CYCLES = 32,
  parameter int RESP_TIMEOUT   = 4096,
  parameter int DCNT_W         = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid_i,
  input  logic                 frame_error_i,
  input  logic [7:0]           parser_error_status_i,
  input  logic [7:0]           parser_cmd_i,
  input  logic [31:0]          parser_addr_i,
  output logic                 frame_consumed_o,
  output logic                 axi_start_o,
  input  logic                 axi_done_i,
  input  logic [7:0]           axi_status_i,
  input  logic [DCNT_W-1:0]    axi_rd_count_i,
  output logic                 build_response_o,
  output logic [7:0]           status_code_o,
  output logic [7:0]           cmd_echo_o,
  output logic [31:0]          addr_echo_o,
  output logic                 is_read_response_o,
  output logic [DCNT_W-1:0]    resp_data_count_o,
  input  logic                 response_complete_i,
  input  logic                 stats_clear_i,
  output logic [CNT_WIDTH-1:0] wr_count_o,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [CNT_WIDTH-1:0] retry_count_o,
  output logic                 resp_timeout_flag_o,
  output logic                 seq_busy_o
);

  // Counter widths are guarded so degenerate parameters (no retries, a
  // single backoff cycle) still give legal one-bit registers.
  localparam int ATT_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int BO_W  = (BACKOFF_CYCLES < 2) ? 1 : $clog2(BACKOFF_CYCLES);
  localparam int WD_W  = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);

  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRIES);
  localparam logic [BO_W-1:0]  BO_LOAD = BO_W'(BACKOFF_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(RESP_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        status_q, status_d;
  logic [DCNT_W-1:0] rdCount_q, rdCount_d;
  logic              err_q, err_d;
  logic [ATT_W-1:0]  attempts_q, attempts_d;
  logic [BO_W-1:0]   backoffCnt_q, backoffCnt_d;
  logic [WD_W-1:0]   watchdog_q, watchdog_d;
  logic              timeoutFlag_q, timeoutFlag_d;

  logic wrInc;
  logic rdInc;
  logic errInc;
  logic retryInc;
  logic consumed;
  logic timeoutSet;
  logic respPhase;
  logic isRead;

  // Next-state, context capture and single-cycle event decode.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    status_d     = status_q;
    rdCount_d    = rdCount_q;
    err_d        = err_q;
    attempts_d   = attempts_q;
    backoffCnt_d = backoffCnt_q;
    watchdog_d   = watchdog_q;
    wrInc        = 1'b0;
    rdInc        = 1'b0;
    errInc       = 1'b0;
    retryInc     = 1'b0;
    consumed     = 1'b0;
    timeoutSet   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_valid_i) begin
          cmd_d      = parser_cmd_i;
          addr_d     = parser_addr_i;
          status_d   = STATUS_OK;
          rdCount_d  = '0;
          err_d      = 1'b0;
          attempts_d = '0;
          state_d    = AXI_REQ;
        end else if (frame_error_i) begin
          cmd_d     = parser_cmd_i;
          addr_d    = parser_addr_i;
          status_d  = parser_error_status_i;
          rdCount_d = '0;
          err_d     = 1'b1;
          state_d   = BUILD;
        end
      end

      AXI_REQ: begin
        if (axi_done_i) begin
          if (is_retryable(axi_status_i) && (attempts_q < ATT_MAX)) begin
            attempts_d   = attempts_q + ATT_W'(1);
            retryInc     = 1'b1;
            backoffCnt_d = BO_LOAD;
            state_d      = BACKOFF;
          end else begin
            status_d  = axi_status_i;
            rdCount_d = axi_rd_count_i;
            state_d   = BUILD;
          end
        end
      end

      BACKOFF: begin
        if (backoffCnt_q == '0) begin
          state_d = AXI_REQ;
        end else begin
          backoffCnt_d = backoffCnt_q - BO_W'(1);
        end
      end

      BUILD: begin
        watchdog_d = WD_LOAD;
        state_d    = WAIT_RESP;
      end

      WAIT_RESP: begin
        // Completion is checked first so a completion landing on the
        // expiry cycle is treated as a normal finish.
        if (response_complete_i) begin
          consumed = 1'b1;
          state_d  = IDLE;
          if (err_q || (status_q != STATUS_OK)) begin
            errInc = 1'b1;
          end else if (cmd_q[7]) begin
            rdInc = 1'b1;
          end else begin
            wrInc = 1'b1;
          end
        end else if (watchdog_q == '0) begin
          consumed   = 1'b1;
          timeoutSet = 1'b1;
          errInc     = 1'b1;
          state_d    = IDLE;
        end else begin
          watchdog_d = watchdog_q - WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (stats_clear_i) begin
      timeoutFlag_d = 1'b0;
    end else begin
      timeoutFlag_d = timeoutFlag_q | timeoutSet;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      addr_q        <= '0;
      status_q      <= '0;
      rdCount_q     <= '0;
      err_q         <= 1'b0;
      attempts_q    <= '0;
      backoffCnt_q  <= '0;
      watchdog_q    <= '0;
      timeoutFlag_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      status_q      <= status_d;
      rdCount_q     <= rdCount_d;
      err_q         <= err_d;
      attempts_q    <= attempts_d;
      backoffCnt_q  <= backoffCnt_d;
      watchdog_q    <= watchdog_d;
      timeoutFlag_q <= timeoutFlag_d;
    end
  end

  // Response fields are only presented while the builder is being served.
  assign respPhase = (state_q == BUILD) || (state_q == WAIT_RESP);
  assign isRead    = cmd_q[7] & ~err_q;

  assign axi_start_o         = (state_q == AXI_REQ);
  assign build_response_o    = (state_q == BUILD);
  assign frame_consumed_o    = consumed;
  assign seq_busy_o          = (state_q != IDLE);
  assign status_code_o       = respPhase ? status_q : 8'h00;
  assign cmd_echo_o          = respPhase ? cmd_q : 8'h00;
  assign addr_echo_o         = respPhase ? addr_q : 32'h0;
  assign is_read_response_o  = respPhase & isRead;
  assign resp_data_count_o   = (respPhase && isRead && (status_q == STATUS_OK)) ?
                               rdCount_q : '0;
  assign resp_timeout_flag_o = timeoutFlag_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) uWrCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (wrInc),
    .clr_i   (stats_clear_i),
    .value_o (wr_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uRdCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (rdInc),
    .clr_i   (stats_clear_i),
    .value_o (rd_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uErrCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (errInc),
    .clr_i   (stats_clear_i),
    .value_o (err_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uRetryCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retryInc),
    .clr_i   (stats_clear_i),
    .value_o (retry_count_o)
  );

endmodule

// File: tb/tb_bridge_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bridge_sequencer
// Directed bench for bridge_sequencer. Expected responses are queued when a
// frame is issued; a monitor pops one whenever build_response is seen and
// compares the presented response fields. Counter, latency and flag values
// are checked against hand-computed constants from the stimulus thread.
// Small parameters keep retries, backoff, watchdog and saturation short.
// ----------------------------------------------------------------------------
module tb_bridge_sequencer;

  localparam int CNT_WIDTH      = 3;
  localparam int MAX_RETRIES    = 2;
  localparam int BACKOFF_CYCLES = 8;
  localparam int RESP_TIMEOUT   = 16;
  localparam int DCNT_W         = 6;

  logic                 clk;
  logic                 rst;
  logic                 frame_valid;
  logic                 frame_error;
  logic [7:0]           parser_error_status;
  logic [7:0]           parser_cmd;
  logic [31:0]          parser_addr;
  logic                 frame_consumed;
  logic                 axi_start;
  logic                 axi_done;
  logic [7:0]           axi_status;
  logic [DCNT_W-1:0]    axi_rd_count;
  logic                 build_response;
  logic [7:0]           status_code;
  logic [7:0]           cmd_echo;
  logic [31:0]          addr_echo;
  logic                 is_read_response;
  logic [DCNT_W-1:0]    resp_data_count;
  logic                 response_complete;
  logic                 stats_clear;
  logic [CNT_WIDTH-1:0] wr_count;
  logic [CNT_WIDTH-1:0] rd_count;
  logic [CNT_WIDTH-1:0] err_count;
  logic [CNT_WIDTH-1:0] retry_count;
  logic                 resp_timeout_flag;
  logic                 seq_busy;

  typedef struct {
    logic [7:0]        status;
    logic [7:0]        cmd;
    logic [31:0]       addr;
    logic              isRead;
    logic [DCNT_W-1:0] dcnt;
  } resp_t;

  resp_t expQ[$];
  int    checkCount = 0;
  int    failCount  = 0;
  int    cycleCnt   = 0;

  bridge_sequencer #(
    .CNT_WIDTH      (CNT_WIDTH),
    .MAX_RETRIES    (MAX_RETRIES),
    .BACKOFF_CYCLES (BACKOFF_CYCLES),
    .RESP_TIMEOUT   (RESP_TIMEOUT),
    .DCNT_W         (DCNT_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .frame_valid_i         (frame_valid),
    .frame_error_i         (frame_error),
    .parser_error_status_i (parser_error_status),
    .parser_cmd_i          (parser_cmd),
    .parser_addr_i         (parser_addr),
    .frame_consumed_o      (frame_consumed),
    .axi_start_o           (axi_start),
    .axi_done_i            (axi_done),
    .axi_status_i          (axi_status),
    .axi_rd_count_i        (axi_rd_count),
    .build_response_o      (build_response),
    .status_code_o         (status_code),
    .cmd_echo_o            (cmd_echo),
    .addr_echo_o           (addr_echo),
    .is_read_response_o    (is_read_response),
    .resp_data_count_o     (resp_data_count),
    .response_complete_i   (response_complete),
    .stats_clear_i         (stats_clear),
    .wr_count_o            (wr_count),
    .rd_count_o            (rd_count),
    .err_count_o           (err_count),
    .retry_count_o         (retry_count),
    .resp_timeout_flag_o   (resp_timeout_flag),
    .seq_busy_o            (seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic boundExpired(input string name);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic pushExp(input logic [7:0] st, input logic [7:0] cmd,
                         input logic [31:0] addr, input logic isRd,
                         input logic [DCNT_W-1:0] dcnt);
    resp_t r;
    r.status = st;
    r.cmd    = cmd;
    r.addr   = addr;
    r.isRead = isRd;
    r.dcnt   = dcnt;
    expQ.push_back(r);
  endtask

  // Scoreboard monitor: one expected entry per builder trigger.
  always @(negedge clk) begin
    if (!rst && build_response) begin
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected_build: got build_response, expected none queued");
      end else begin
        resp_t e;
        e = expQ.pop_front();
        checkOutput("resp_status", 64'(status_code), 64'(e.status));
        checkOutput("resp_cmd", 64'(cmd_echo), 64'(e.cmd));
        checkOutput("resp_addr", 64'(addr_echo), 64'(e.addr));
        checkOutput("resp_is_read", 64'(is_read_response), 64'(e.isRead));
        checkOutput("resp_dcnt", 64'(resp_data_count), 64'(e.dcnt));
      end
    end
  end

  // Presents a good frame for one cycle, called at a negedge while idle.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic alsoError);
    frame_valid         = 1'b1;
    frame_error         = alsoError;
    parser_error_status = 8'h09;
    parser_cmd          = cmd;
    parser_addr         = addr;
    @(negedge clk);
    frame_valid = 1'b0;
    frame_error = 1'b0;
    checkOutput("accept_latency", 64'(axi_start), 64'd1);
  endtask

  // Waits for axi_start, then answers with a one-cycle axi_done.
  task automatic axiRespond(input logic [7:0] st, input logic [DCNT_W-1:0] rdc,
                            output int doneCycle);
    int waited = 0;
    while (!axi_start && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!axi_start) boundExpired("axi_start_wait");
    doneCycle    = cycleCnt;
    axi_done     = 1'b1;
    axi_status   = st;
    axi_rd_count = rdc;
    @(negedge clk);
    axi_done     = 1'b0;
    axi_status   = 8'h00;
    axi_rd_count = '0;
  endtask

  // Called at the negedge where build_response is high.
  task automatic completeResponse(input logic clr);
    checkOutput("build_latency", 64'(build_response), 64'd1);
    @(negedge clk);
    checkOutput("build_one_cycle", 64'(build_response), 64'd0);
    response_complete = 1'b1;
    stats_clear       = clr;
    #1;
    checkOutput("consumed_same_cycle", 64'(frame_consumed), 64'd1);
    @(negedge clk);
    response_complete = 1'b0;
    stats_clear       = 1'b0;
    checkOutput("idle_after_consume", 64'(seq_busy), 64'd0);
  endtask

  initial begin
    int d0, d1, d2, buildCycle, waited;
    rst                 = 1'b1;
    frame_valid         = 1'b0;
    frame_error         = 1'b0;
    parser_error_status = 8'h00;
    parser_cmd          = 8'h00;
    parser_addr         = 32'h0;
    axi_done            = 1'b0;
    axi_status          = 8'h00;
    axi_rd_count        = '0;
    response_complete   = 1'b0;
    stats_clear         = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_axi_start", 64'(axi_start), 64'd0);
    checkOutput("rst_build", 64'(build_response), 64'd0);
    checkOutput("rst_consumed", 64'(frame_consumed), 64'd0);
    checkOutput("rst_busy", 64'(seq_busy), 64'd0);
    checkOutput("rst_status", 64'(status_code), 64'd0);
    checkOutput("rst_addr_echo", 64'(addr_echo), 64'd0);
    checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
    checkOutput("rst_flag", 64'(resp_timeout_flag), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] write ok, frame_error held alongside frame_valid");
    pushExp(8'h00, 8'h20, 32'h0000_1000, 1'b0, 6'd0);
    applyStimulus(8'h20, 32'h0000_1000, 1'b1);
    axiRespond(8'h00, 6'd0, d0);
    completeResponse(1'b0);
    checkOutput("write_wr_count", 64'(wr_count), 64'd1);

    $display("[TB] read ok");
    pushExp(8'h00, 8'hA3, 32'h2000_0004, 1'b1, 6'd4);
    applyStimulus(8'hA3, 32'h2000_0004, 1'b0);
    axiRespond(8'h00, 6'd4, d0);
    completeResponse(1'b0);
    checkOutput("read_rd_count", 64'(rd_count), 64'd1);

    $display("[TB] retry busy then timeout then ok");
    pushExp(8'h00, 8'h21, 32'h0000_3000, 1'b0, 6'd0);
    applyStimulus(8'h21, 32'h0000_3000, 1'b0);
    axiRespond(8'h06, 6'd0, d0);
    checkOutput("backoff_start_low", 64'(axi_start), 64'd0);
    axiRespond(8'h04, 6'd0, d1);
    checkOutput("retry_gap_1", 64'(d1 - d0), 64'd9);
    axiRespond(8'h00, 6'd0, d2);
    checkOutput("retry_gap_2", 64'(d2 - d1), 64'd9);
    completeResponse(1'b0);
    checkOutput("retry_retry_count", 64'(retry_count), 64'd2);
    checkOutput("retry_wr_count", 64'(wr_count), 64'd2);

    $display("[TB] retry exhaustion");
    pushExp(8'h06, 8'h80, 32'h0000_0040, 1'b1, 6'd0);
    applyStimulus(8'h80, 32'h0000_0040, 1'b0);
    axiRespond(8'h06, 6'd5, d0);
    axiRespond(8'h06, 6'd5, d0);
    axiRespond(8'h06, 6'd5, d0);
    completeResponse(1'b0);
    checkOutput("exhaust_err_count", 64'(err_count), 64'd1);
    checkOutput("exhaust_retry_count", 64'(retry_count), 64'd4);

    $display("[TB] parser error");
    pushExp(8'h01, 8'h85, 32'h0000_0055, 1'b0, 6'd0);
    frame_error         = 1'b1;
    parser_error_status = 8'h01;
    parser_cmd          = 8'h85;
    parser_addr         = 32'h0000_0055;
    @(negedge clk);
    frame_error = 1'b0;
    checkOutput("error_no_axi_start", 64'(axi_start), 64'd0);
    completeResponse(1'b0);
    checkOutput("error_err_count", 64'(err_count), 64'd2);

    $display("[TB] response watchdog");
    pushExp(8'h00, 8'h22, 32'h0000_5000, 1'b0, 6'd0);
    applyStimulus(8'h22, 32'h0000_5000, 1'b0);
    axiRespond(8'h00, 6'd0, d0);
    checkOutput("wd_build_latency", 64'(build_response), 64'd1);
    buildCycle = cycleCnt;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!frame_consumed && waited < 40);
    if (!frame_consumed) boundExpired("watchdog_wait");
    checkOutput("wd_expiry_cycle", 64'(cycleCnt - buildCycle), 64'd16);
    @(negedge clk);
    checkOutput("wd_idle", 64'(seq_busy), 64'd0);
    checkOutput("wd_flag", 64'(resp_timeout_flag), 64'd1);
    checkOutput("wd_err_count", 64'(err_count), 64'd3);
    checkOutput("wd_wr_count", 64'(wr_count), 64'd2);

    $display("[TB] write counter saturation");
    for (int i = 0; i < 8; i++) begin
      pushExp(8'h00, 8'(8'h01 + i), 32'h0000_7000 + 32'(i * 4), 1'b0, 6'd0);
      applyStimulus(8'(8'h01 + i), 32'h0000_7000 + 32'(i * 4), 1'b0);
      axiRespond(8'h00, 6'd0, d0);
      completeResponse(1'b0);
      if (i == 4) checkOutput("sat_reach_max", 64'(wr_count), 64'd7);
    end
    checkOutput("sat_hold_max", 64'(wr_count), 64'd7);

    $display("[TB] stats_clear coincident with completion");
    pushExp(8'h00, 8'h24, 32'h0000_8000, 1'b0, 6'd0);
    applyStimulus(8'h24, 32'h0000_8000, 1'b0);
    axiRespond(8'h00, 6'd0, d0);
    completeResponse(1'b1);
    checkOutput("clr_wr_count", 64'(wr_count), 64'd0);
    checkOutput("clr_rd_count", 64'(rd_count), 64'd0);
    checkOutput("clr_err_count", 64'(err_count), 64'd0);
    checkOutput("clr_retry_count", 64'(retry_count), 64'd0);
    checkOutput("clr_flag", 64'(resp_timeout_flag), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h30, 32'h0000_6000, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(seq_busy), 64'd0);
    checkOutput("midrst_axi_start", 64'(axi_start), 64'd0);
    checkOutput("midrst_consumed", 64'(frame_consumed), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stays_idle", 64'(seq_busy), 64'd0);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
